// File: rtl/operand_loader_pkg.sv
// ============================================================================
// Module   : operand_loader_pkg
// Purpose  : Shared FSM state type, operand register indices and defaults
//            for the operand loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package operand_loader_pkg;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_NUM_REGS = 3;

    localparam int REG_A  = 0;
    localparam int REG_B  = 1;
    localparam int REG_OP = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/operand_loader_if.sv
// ============================================================================
// Module   : operand_loader_if
// Purpose  : Switch/button, control-unit and readback signals of the
//            operand loader. slave = loader side, master = environment side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface operand_loader_if #(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 3
);
    localparam int SEL_W = $clog2(NUM_REGS + 1);

    logic [WIDTH-1:0]          data_in;
    logic [SEL_W-1:0]          sel;
    logic                      load_strobe;
    logic                      auto_mode;
    logic                      wb_valid;
    logic [WIDTH-1:0]          wb_data;
    logic [WIDTH-1:0]          buf_in;
    logic                      frame_ack;
    logic [NUM_REGS*WIDTH-1:0] regs_out;
    logic [WIDTH-1:0]          choice_out;
    logic [WIDTH-1:0]          led_out;
    logic                      frame_valid;
    logic [SEL_W-1:0]          wr_ptr;

    modport slave (
        input  data_in, sel, load_strobe, auto_mode, wb_valid, wb_data,
               buf_in, frame_ack,
        output regs_out, choice_out, led_out, frame_valid, wr_ptr
    );

    modport master (
        output data_in, sel, load_strobe, auto_mode, wb_valid, wb_data,
               buf_in, frame_ack,
        input  regs_out, choice_out, led_out, frame_valid, wr_ptr
    );

endinterface

`default_nettype wire

// File: rtl/strobe_edge_detect.sv
// ============================================================================
// Module   : strobe_edge_detect
// Purpose  : One-cycle pulse on the rising edge of the load button. With
//            OPERAND_LOADER_SYNC_EN defined the button first passes a 2-flop
//            synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module strobe_edge_detect (
    input  wire logic clock,
    input  wire logic reset_n,
    input  wire logic i_strobe,
    output logic      o_pulse
);

    logic w_strobe;
    logic r_strobe_q;

`ifdef OPERAND_LOADER_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_strobe;
            r_sync2 <= r_sync1;
        end
    end

    assign w_strobe = r_sync2;
`else
    assign w_strobe = i_strobe;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_strobe_q <= 1'b0;
        end else begin
            r_strobe_q <= w_strobe;
        end
    end

    assign o_pulse = w_strobe & ~r_strobe_q;

endmodule

`default_nettype wire

// File: rtl/operand_loader.sv
// ============================================================================
// Module   : operand_loader
// Purpose  : Operand register bank with manual/auto-fill loading, priority
//            writeback into reg 0, registered readback and LED mirror.
//            Optional macro: OPERAND_LOADER_SYNC_EN (button synchroniser).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int NUM_REGS = DEFAULT_NUM_REGS
) (
    input  wire logic        clock,
    input  wire logic        reset_n,
    operand_loader_if.slave  bus
);

    localparam int                SEL_W     = $clog2(NUM_REGS + 1);
    localparam logic [SEL_W-1:0]  c_LAST    = SEL_W'(NUM_REGS - 1);
    localparam logic [SEL_W-1:0]  c_BUF_SEL = SEL_W'(NUM_REGS);

    state_t            r_state;
    logic [SEL_W-1:0]  r_wr_ptr;
    logic              r_frame_valid;
    logic [WIDTH-1:0]  r_regs [NUM_REGS];
    logic [WIDTH-1:0]  r_choice;
    logic [WIDTH-1:0]  r_led;

    logic              w_pulse;
    logic              w_wr_en;
    logic [SEL_W-1:0]  w_wr_idx;
    logic [WIDTH-1:0]  w_choice;

    strobe_edge_detect u_edge (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_strobe (bus.load_strobe),
        .o_pulse  (w_pulse)
    );

    // Strobe write target: sel when idle in manual mode, wr_ptr while filling.
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = bus.sel;
        case (r_state)
            IDLE: begin
                w_wr_en  = w_pulse & ~bus.auto_mode & (bus.sel < c_BUF_SEL);
                w_wr_idx = bus.sel;
            end
            FILL: begin
                w_wr_en  = w_pulse & bus.auto_mode;
                w_wr_idx = r_wr_ptr;
            end
            default: begin
                w_wr_en  = 1'b0;
                w_wr_idx = bus.sel;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_wr_ptr      <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wr_ptr      <= '0;
                    r_frame_valid <= 1'b0;
                    if (bus.auto_mode) begin
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    if (!bus.auto_mode) begin
                        r_state  <= IDLE;
                        r_wr_ptr <= '0;
                    end else if (w_pulse) begin
                        // Pointer advances even if writeback stole reg 0.
                        if (r_wr_ptr == c_LAST) begin
                            r_state       <= READY;
                            r_wr_ptr      <= '0;
                            r_frame_valid <= 1'b1;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + SEL_W'(1);
                        end
                    end
                end
                READY: begin
                    if (!bus.auto_mode) begin
                        r_state       <= IDLE;
                        r_frame_valid <= 1'b0;
                    end else if (bus.frame_ack) begin
                        r_state       <= FILL;
                        r_frame_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_wr_ptr      <= '0;
                    r_frame_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == REG_A && bus.wb_valid) begin
                    r_regs[i] <= bus.wb_data;
                end else if (w_wr_en && w_wr_idx == SEL_W'(i)) begin
                    r_regs[i] <= bus.data_in;
                end
            end
        end
    end

    always_comb begin
        w_choice = '0;
        if (bus.sel == c_BUF_SEL) begin
            w_choice = bus.buf_in;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                w_choice = r_regs[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_choice <= '0;
            r_led    <= '0;
        end else begin
            r_choice <= w_choice;
            r_led    <= bus.data_in;
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign bus.regs_out[gi*WIDTH +: WIDTH] = r_regs[gi];
    end

    assign bus.choice_out  = r_choice;
    assign bus.led_out     = r_led;
    assign bus.frame_valid = r_frame_valid;
    assign bus.wr_ptr      = r_wr_ptr;

endmodule

`default_nettype wire

// File: tb/tb_operand_loader.sv
// ============================================================================
// Module   : tb_operand_loader
// Purpose  : Directed and randomized checks of operand_loader against a
//            behavioural model of the loading rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_loader;

    localparam int W = 8;
    localparam int N = 3;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    operand_loader_if #(.WIDTH(W), .NUM_REGS(N)) bus ();

    operand_loader #(.WIDTH(W), .NUM_REGS(N)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model
    logic [W-1:0] m_regs [N];
    bit           m_filling;
    bit           m_ready;
    int           m_ptr;
    logic [W-1:0] m_choice;
    logic [W-1:0] m_led;
    bit           m_hist [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        for (int i = 0; i < 4; i++) m_hist[i] = 1'b0;
        m_filling = 1'b0;
        m_ready   = 1'b0;
        m_ptr     = 0;
        m_choice  = '0;
        m_led     = '0;
    endtask

    task automatic model_write(input int idx, input logic [W-1:0] d);
        if (!(idx == 0 && bus.wb_valid)) m_regs[idx] = d;
    endtask

    // Called on a rising edge, with the inputs as sampled by that edge.
    task automatic model_edge();
        bit pulse;
        int s;
        for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = bus.load_strobe;
`ifdef OPERAND_LOADER_SYNC_EN
        pulse = m_hist[2] & ~m_hist[3];
`else
        pulse = m_hist[0] & ~m_hist[1];
`endif
        s = int'(bus.sel);
        if (s < N)       m_choice = m_regs[s];
        else if (s == N) m_choice = bus.buf_in;
        else             m_choice = '0;
        m_led = bus.data_in;

        if (!bus.auto_mode) begin
            if (!m_filling && !m_ready && pulse && s < N) model_write(s, bus.data_in);
            m_filling = 1'b0;
            m_ready   = 1'b0;
            m_ptr     = 0;
        end else if (m_ready) begin
            if (bus.frame_ack) begin
                m_ready   = 1'b0;
                m_filling = 1'b1;
            end
        end else if (m_filling) begin
            if (pulse) begin
                model_write(m_ptr, bus.data_in);
                if (m_ptr == N - 1) begin
                    m_ptr     = 0;
                    m_filling = 1'b0;
                    m_ready   = 1'b1;
                end else begin
                    m_ptr = m_ptr + 1;
                end
            end
        end else begin
            m_filling = 1'b1;
            m_ptr     = 0;
        end
        if (bus.wb_valid) m_regs[0] = bus.wb_data;
    endtask

    task automatic compare_all();
        chk("regs_out",    32'(bus.regs_out),    32'({m_regs[2], m_regs[1], m_regs[0]}));
        chk("choice_out",  32'(bus.choice_out),  32'(m_choice));
        chk("led_out",     32'(bus.led_out),     32'(m_led));
        chk("frame_valid", 32'(bus.frame_valid), 32'(m_ready));
        chk("wr_ptr",      32'(bus.wr_ptr),      32'(m_ptr));
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clock);
        #2;
        compare_all();
        reset_n = 1'b1;
    endtask

    task automatic pulse(input logic [W-1:0] d);
        bus.data_in     = d;
        bus.load_strobe = 1'b1;
        cycle();
        bus.load_strobe = 1'b0;
        repeat (3) cycle();
    endtask

    initial begin
        bus.data_in     = '0;
        bus.sel         = '0;
        bus.load_strobe = 1'b0;
        bus.auto_mode   = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_data     = '0;
        bus.buf_in      = '0;
        bus.frame_ack   = 1'b0;
        model_reset();

        #2;
        chk("reset_regs", 32'(bus.regs_out), 32'h0);
        do_reset();
        cycle();

        // Manual load, button held: data changes later must not be written.
        bus.sel         = 2'd1;
        bus.data_in     = 8'h5A;
        bus.load_strobe = 1'b1;
        repeat (3) cycle();
        bus.data_in = 8'h77;
        repeat (2) cycle();
        bus.load_strobe = 1'b0;
        repeat (2) cycle();
        chk("manual_reg1", 32'(bus.regs_out[15:8]), 32'h5A);

        bus.sel    = 2'd3;
        bus.buf_in = 8'hC3;
        cycle();
        chk("buf_readback", 32'(bus.choice_out), 32'hC3);

        // Auto fill
        bus.auto_mode = 1'b1;
        bus.sel       = 2'd0;
        cycle();
        pulse(8'h11);
        pulse(8'h22);
        pulse(8'h33);
        chk("fill_regs",  32'(bus.regs_out), 32'h332211);
        chk("model_pin",  32'({m_regs[2], m_regs[1], m_regs[0]}), 32'h332211);
        chk("fill_valid", 32'(bus.frame_valid), 32'h1);
        pulse(8'h44);
        chk("ready_ignore", 32'(bus.regs_out), 32'h332211);
        bus.frame_ack = 1'b1;
        cycle();
        bus.frame_ack = 1'b0;
        cycle();
        chk("ack_valid", 32'(bus.frame_valid), 32'h0);
        chk("ack_ptr",   32'(bus.wr_ptr), 32'h0);

        // Collision at pointer 0: writeback wins, pointer advances.
        bus.data_in     = 8'h44;
        bus.load_strobe = 1'b1;
`ifdef OPERAND_LOADER_SYNC_EN
        cycle();
        bus.load_strobe = 1'b0;
        cycle();
`endif
        bus.wb_valid = 1'b1;
        bus.wb_data  = 8'h99;
        cycle();
        bus.wb_valid    = 1'b0;
        bus.load_strobe = 1'b0;
        repeat (2) cycle();
        chk("collide_reg0", 32'(bus.regs_out[7:0]), 32'h99);
        chk("collide_ptr",  32'(bus.wr_ptr), 32'h1);

        // Mode drop at pointer 2
        pulse(8'h55);
        chk("pre_drop_ptr", 32'(bus.wr_ptr), 32'h2);
        bus.auto_mode = 1'b0;
        cycle();
        chk("drop_ptr",   32'(bus.wr_ptr), 32'h0);
        chk("drop_valid", 32'(bus.frame_valid), 32'h0);
        chk("drop_regs",  32'(bus.regs_out), 32'h335599);

        // Reset mid-fill after one write
        bus.auto_mode = 1'b1;
        cycle();
        pulse(8'h66);
        do_reset();
        chk("rst_regs",   32'(bus.regs_out), 32'h0);
        chk("rst_ptr",    32'(bus.wr_ptr), 32'h0);
        chk("rst_choice", 32'(bus.choice_out), 32'h0);
        chk("rst_led",    32'(bus.led_out), 32'h0);
        cycle();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(49, 0) == 0) bus.auto_mode = ~bus.auto_mode;
            if ($urandom_range(2, 0) == 0)  bus.load_strobe = ~bus.load_strobe;
            bus.sel       = 2'($urandom_range(3, 0));
            bus.data_in   = 8'($urandom);
            bus.wb_valid  = ($urandom_range(7, 0) == 0);
            bus.wb_data   = 8'($urandom);
            bus.buf_in    = 8'($urandom);
            bus.frame_ack = ($urandom_range(3, 0) == 0);
            if (c == 1500) do_reset();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
